// File: rtl/enc_controller.sv
// Reed-Solomon encoder sequencing controller: paces the input buffer and emits
// half beat, message beats, parity beats per codeword. Option: ENC_CON_STALL_CNT_EN.
module enc_controller #(
    parameter int RS_COD_LEN  = 255,
    parameter int RS_MES_LEN  = 239,
    parameter int ENC_SYM_NUM = 16,
    parameter int EGF_ORDER   = 8,
    parameter int CON_PHASE   = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(ENC_SYM_NUM+1)-1:0]   buf_valid,
    input  logic                               out_ready,
    output logic [CON_PHASE-1:0]               con_phase,
    output logic [$clog2(RS_COD_LEN)-1:0]      con_counter,
    output logic [$clog2(ENC_SYM_NUM+1)-1:0]   con_pop,
    output logic                               con_out_valid,
    output logic                               con_out_last,
    output logic [15:0]                        con_stall_cnt
);

    localparam int BW = $clog2(ENC_SYM_NUM + 1);
    localparam int CW = $clog2(RS_COD_LEN);
    localparam int H  = RS_MES_LEN % ENC_SYM_NUM;
    localparam int P  = RS_COD_LEN - RS_MES_LEN;

    localparam logic [CW:0]   MES_X = (CW+1)'(RS_MES_LEN);
    localparam logic [CW:0]   PAR_X = (CW+1)'(P);
    localparam logic [CW-1:0] H_X   = CW'(H);
    localparam logic [CW-1:0] S_X   = CW'(ENC_SYM_NUM);

    if ((RS_MES_LEN - H) % ENC_SYM_NUM != 0) begin : g_bad_len
        $error("enc_controller: message length not half beat plus whole beats");
    end
    if (EGF_ORDER < 1) begin : g_bad_sym
        $error("enc_controller: symbol width must be positive");
    end

    typedef enum logic [CON_PHASE-1:0] {
        CON_IDL = 'd0,
        CON_WOR = 'd1,
        CON_PAR = 'd2
    } phase_t;

    phase_t          state;
    phase_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [CW-1:0]   need;
    logic [CW-1:0]   bv_ext;
    logic [CW:0]     sum;
    logic            have;

    // Phase and symbol counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CON_IDL;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state, pop count and beat handshake decode
    always_comb begin
        bv_ext        = CW'(buf_valid);
        need          = (state == CON_WOR && cnt == '0) ? H_X : S_X;
        have          = bv_ext >= need;
        sum           = {1'b0, cnt} + {1'b0, need};
        state_nx      = state;
        cnt_nx        = cnt;
        con_pop       = '0;
        con_out_valid = 1'b0;
        con_out_last  = 1'b0;
        unique case (state)
            CON_IDL: begin
                if (bv_ext >= H_X) begin
                    state_nx = CON_WOR;
                    cnt_nx   = '0;
                end
            end
            CON_WOR: begin
                con_out_valid = have;
                if (have && out_ready) begin
                    con_pop = BW'(need);
                    if (sum >= MES_X) begin
                        state_nx = CON_PAR;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = sum[CW-1:0];
                    end
                end
            end
            CON_PAR: begin
                con_out_valid = 1'b1;
                con_out_last  = sum >= PAR_X;
                if (out_ready) begin
                    if (con_out_last) begin
                        state_nx = (bv_ext >= H_X) ? CON_WOR : CON_IDL;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = sum[CW-1:0];
                    end
                end
            end
            default: begin
                state_nx = CON_IDL;
                cnt_nx   = '0;
            end
        endcase
    end

    assign con_phase   = state;
    assign con_counter = cnt;

`ifdef ENC_CON_STALL_CNT_EN
    logic        stall;
    logic [15:0] stall_q;

    assign stall = (state == CON_WOR) && out_ready && !have;

    // Saturating count of starved message cycles, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign con_stall_cnt = stall_q;
`else
    assign con_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_enc_controller.sv
// Scoreboard bench for enc_controller: beat-level reference model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_enc_controller;

    localparam int S  = 16;
    localparam int H  = 239 % 16;
    localparam int MB = (239 - H) / 16;
    localparam int NB = 1 + MB + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] buf_valid;
    logic       out_ready;
    logic [1:0] con_phase;
    logic [7:0] con_counter;
    logic [4:0] con_pop;
    logic       con_out_valid;
    logic       con_out_last;
    logic [15:0] con_stall_cnt;

    enc_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .buf_valid     (buf_valid),
        .out_ready     (out_ready),
        .con_phase     (con_phase),
        .con_counter   (con_counter),
        .con_pop       (con_pop),
        .con_out_valid (con_out_valid),
        .con_out_last  (con_out_last),
        .con_stall_cnt (con_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int cnt;
        int pop;
        int vld;
        int lst;
        int stl;
    } exp_t;

    exp_t sbq[$];
    int   nchk  = 0;
    int   npass = 0;

    // Model state: codeword is a sequence of NB beats, beat k in order
    bit known   = 1'b0;
    bit act     = 1'b0;
    int k       = 0;
    int stall_m = 0;

    function automatic void chk(string n, int a, int e);
        nchk++;
        if (a == e) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    endfunction

    task automatic step(input int bv, input bit rdy, input bit rst);
        exp_t e;
        int   need;
        bit   par;
        buf_valid = 5'(bv);
        out_ready = rdy;
        rst_n     = rst;
        need = (k == 0) ? H : S;
        par  = act && (k > MB);
        e = '{default: 0};
        if (act && !par) begin
            e.ph  = 1;
            e.cnt = (k == 0) ? 0 : H + (k - 1) * S;
            e.vld = (bv >= need);
            e.pop = (e.vld && rdy) ? need : 0;
        end else if (par) begin
            e.ph  = 2;
            e.cnt = (k - MB - 1) * S;
            e.vld = 1;
            e.lst = (k == NB - 1);
        end
`ifdef ENC_CON_STALL_CNT_EN
        e.stl = stall_m;
`endif
        if (known) sbq.push_back(e);
        @(posedge clk);
        #1;
        if (!rst) begin
            known   = 1'b1;
            act     = 1'b0;
            k       = 0;
            stall_m = 0;
        end else if (known) begin
            if (!act) begin
                if (bv >= H) begin
                    act = 1'b1;
                    k   = 0;
                end
            end else if (!par) begin
                if (rdy && bv < need && stall_m < 65535) stall_m++;
                if (rdy && bv >= need) k++;
            end else if (rdy) begin
                if (k == NB - 1) begin
                    if (bv >= H) k = 0;
                    else act = 1'b0;
                end else begin
                    k++;
                end
            end
        end
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("phase",   int'(con_phase),     e.ph);
                chk("counter", int'(con_counter),   e.cnt);
                chk("pop",     int'(con_pop),       e.pop);
                chk("valid",   int'(con_out_valid), e.vld);
                chk("last",    int'(con_out_last),  e.lst);
                chk("stall",   int'(con_stall_cnt), e.stl);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        buf_valid = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // reset then idle
        repeat (2) step(0, 0, 0);
        repeat (6) step(0, 1, 1);
        // back-to-back codewords, then backpressure at counter 47
        repeat (20) step(16, 1, 1);
        repeat (3) step(16, 0, 1);
        repeat (13) step(16, 1, 1);
        // starvation at counter 15
        step(16, 1, 1);
        repeat (4) step(10, 1, 1);
        // oversupply is harmless, then end of stream after parity
        repeat (14) step(16, 1, 1);
        step(0, 1, 1);
        repeat (3) step(0, 1, 1);
        // reset at counter 127
        repeat (9) step(16, 1, 1);
        step(16, 1, 0);
        repeat (2) step(0, 1, 1);
        // randomized traffic
        repeat (3000) begin
            int bv;
            bit rdy;
            bit rst;
            bv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16))
                                              : int'($urandom_range(14, 16));
            rdy = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 299) != 0);
            step(bv, rdy, rst);
        end
        repeat (3) @(posedge clk);
        nchk++;
        if (sbq.size() == 0) npass++;
        else $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
